boot_stream_loader: RTL and testbench
=====================================

// Module: boot_stream_loader
// PURPOSE
//  Parametrised byte-stream bootloader. Pulls bytes from a UART-style byte source and parses a
//  frame: LEN_BYTES length header (MSB first), payload, then optional 1-byte checksum.
//  Packs payload into full WORD_BYTES-wide words, one BRAM write per word, and raises boot_ready.
//  Sits between the UART reader and the instruction BRAM port; the CPU is held until boot_ready.
// PARAMETERS
//  WORD_BYTES  4          bytes per BRAM word (1,2,4,8); DATA_W = 8*WORD_BYTES
//  ADDR_W      32         BRAM byte-address width
//  LEN_BYTES   2          length header bytes (1..4), MSB first
//  BASE_ADDR   0          byte address of payload byte 0 (WORD_BYTES-aligned)
//  MAX_BYTES   65536      largest accepted payload; larger length -> error
//  BIG_ENDIAN  1          1: first byte of word -> MS lane; 0: first byte -> LS lane
//  CSUM_EN     1          1: trailing byte must equal sum(payload) mod 256
// PORTS
//  CLK           in   1           clock, all logic posedge
//  RST           in   1           synchronous reset, active-high
//  io_ready      in   1           source holds >=1 byte
//  io_read_req   out  1           one-cycle read strobe
//  io_done       in   1           io_rdata valid this cycle
//  io_rdata      in   8           received byte
//  mem_addr      out  ADDR_W      BRAM byte address (word-aligned)
//  mem_wdata     out  DATA_W      BRAM write data
//  mem_we        out  WORD_BYTES  per-lane write enables
//  mem_en        out  1           BRAM enable
//  bytes_loaded  out  32          payload bytes accepted so far
//  boot_ready    out  1           high (sticky) once frame loaded and verified
//  err           out  8           0 ok, 1 length>MAX_BYTES, 2 checksum mismatch
// BEHAVIOUR
//  Reset (RST high at posedge, any state): state=S_REQ, all outputs 0, counters/accumulators 0;
//   mem_en/mem_we forced 0 same edge, abandoning any in-flight write.
//  S_REQ: when io_ready=1 -> io_read_req=1 for exactly one cycle, go S_WAIT. Never re-pulsed until
//   the pending byte returns.
//  S_WAIT: io_done sampled every cycle incl. the strobe cycle; on io_done dispatch by phase:
//   LEN: length <= {length, byte}; after LEN_BYTES bytes: length>MAX_BYTES -> err=1, S_HALT;
//        length==0 -> PHASE CSUM (CSUM_EN) else S_RUN; otherwise PHASE DATA, S_REQ.
//   DATA: byte placed in lane k=bytes_loaded%WORD_BYTES (BIG_ENDIAN: lane WORD_BYTES-1-k);
//        sum+=byte (8-bit wrap); bytes_loaded++. If lane completes word or byte is last
//        -> S_WRITE, else S_REQ.
//   CSUM: byte==sum -> S_RUN; else err=2, S_HALT.
//  S_WRITE (1 cycle): mem_en=1, mem_we=lanes received for this word (full word: all ones;
//   final partial word: only filled lanes, unfilled data lanes 0);
//   mem_addr = BASE_ADDR + (bytes_loaded-1)/WORD_BYTES*WORD_BYTES. Next cycle mem_en=mem_we=0,
//   word buffer cleared; go PHASE CSUM/S_RUN if last byte, else S_REQ.
//  Latency: last io_done -> mem_en 1 cycle; boot_ready asserts 1 cycle after final io_done
//   (checksum) or 2 cycles after final io_done when write is last (CSUM_EN=0).
//  S_RUN: boot_ready=1, no further io_read_req; io_done ignored. S_HALT: terminal, err held,
//   boot_ready=0; only RST leaves S_RUN/S_HALT.
//  Widths: length zero-extended to 32 bits; bytes_loaded saturates never (MAX_BYTES<2^32).
//  Spurious io_done outside S_WAIT ignored.
// TESTING
//  1 WORD_BYTES=4,BE: stream 00 08 11 22 33 44 55 66 77 88 csum=0x64 -> writes @0 11223344 we=F,
//    @4 55667788 we=F, boot_ready=1, err=0, bytes_loaded=8.
//  2 Length 5, bytes 01..05, csum 0x0F -> second write @4 wdata=05000000 we=8 (partial word).
//  3 Length 3, bytes AA BB CC, csum 0x00 -> err=2, boot_ready stays 0, no further io_read_req.
//  4 MAX_BYTES=16, header 00 20 -> err=1 after 2nd byte, zero BRAM writes.
//  5 BIG_ENDIAN=0,CSUM_EN=0, len 4 bytes 11 22 33 44 -> wdata=44332211; io_ready held low
//    5 cycles mid-payload -> no strobe until it rises; exactly one strobe per byte.
//  6 RST pulsed during S_WRITE -> mem_en=0 next edge, bytes_loaded=0; resend frame 1 succeeds.

Source files
------------

// File: rtl/boot_stream_loader_if.sv
// boot_stream_loader_if
//   Bundles the byte-source handshake and the instruction BRAM write port
//   of the boot stream loader.
//   Byte source: the loader raises io_read_req for one cycle when io_ready
//   is high. The source answers with io_done=1 and io_rdata in some later
//   cycle, which may be the strobe cycle itself. The loader issues no new
//   request until that byte has returned.
//   BRAM: a write happens in any cycle with mem_en=1. mem_we selects the
//   byte lanes, and mem_addr is a word-aligned byte address.
//   Modports:
//     master - loader side (drives io_read_req and mem_*)
//     slave  - environment side (drives io_ready, io_done, io_rdata)
interface boot_stream_loader_if #(
  parameter int WORD_BYTES = 4,
  parameter int ADDR_W     = 32
);
  localparam int DATA_W = 8 * WORD_BYTES;

  logic                  io_ready;
  logic                  io_read_req;
  logic                  io_done;
  logic [7:0]            io_rdata;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [WORD_BYTES-1:0] mem_we;
  logic                  mem_en;

  modport master (
    input  io_ready, io_done, io_rdata,
    output io_read_req, mem_addr, mem_wdata, mem_we, mem_en
  );

  modport slave (
    output io_ready, io_done, io_rdata,
    input  io_read_req, mem_addr, mem_wdata, mem_we, mem_en
  );
endinterface

// File: rtl/boot_stream_loader.sv
// boot_stream_loader
//   Pulls a boot frame from a byte source and loads it into instruction BRAM.
//   Frame layout: LEN_BYTES length header (MSB first), then the payload,
//   then an optional 1-byte checksum equal to sum(payload) mod 256.
//   The payload is packed into WORD_BYTES-wide words, with one BRAM write
//   per word. A final partial word writes only its filled lanes.
//   Ports:
//     CLK, RST     clock and synchronous active-high reset
//     bus          byte-source handshake + BRAM write port (master modport)
//     bytes_loaded payload bytes accepted so far
//     boot_ready   sticky high once the frame is loaded and verified
//     err          0 ok, 1 length > MAX_BYTES, 2 checksum mismatch
//     dbg_state    current FSM state encoding
module boot_stream_loader #(
  parameter int               WORD_BYTES = 4,
  parameter int               ADDR_W     = 32,
  parameter int               LEN_BYTES  = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int               MAX_BYTES  = 65536,
  parameter bit               BIG_ENDIAN = 1'b1,
  parameter bit               CSUM_EN    = 1'b1
) (
  input  logic                CLK,
  input  logic                RST,
  boot_stream_loader_if.master bus,
  output logic [31:0]         bytes_loaded,
  output logic                boot_ready,
  output logic [7:0]          err,
  output logic [2:0]          dbg_state
);
  localparam int DATA_W = 8 * WORD_BYTES;

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_WRITE = 3'd2,
    S_RUN   = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PH_LEN  = 2'd0,
    PH_DATA = 2'd1,
    PH_CSUM = 2'd2
  } phase_e;

  state_e                state_q, state_d;
  phase_e                phase_q, phase_d;
  logic                  read_req_q, read_req_d;
  logic [2:0]            hdr_cnt_q, hdr_cnt_d;
  logic [31:0]           length_q, length_d;
  logic [31:0]           bytes_q, bytes_d;
  logic [7:0]            sum_q, sum_d;
  logic [DATA_W-1:0]     word_q, word_d;
  logic [WORD_BYTES-1:0] lanes_q, lanes_d;
  logic [7:0]            err_q, err_d;

  logic [31:0]           new_len;
  logic                  last_byte;
  int                    lane_k;
  int                    lane_sel;
  logic [31:0]           word_off;
  logic                  in_write;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    read_req_d = 1'b0;
    hdr_cnt_d  = hdr_cnt_q;
    length_d   = length_q;
    bytes_d    = bytes_q;
    sum_d      = sum_q;
    word_d     = word_q;
    lanes_d    = lanes_q;
    err_d      = err_q;

    new_len   = {length_q[23:0], bus.io_rdata};
    last_byte = ((bytes_q + 32'd1) == length_q);
    // Lane position inside the current word. WORD_BYTES is a power of two
    // no larger than 8, so the low byte of the counter is enough.
    lane_k    = int'(bytes_q[7:0]) % WORD_BYTES;
    lane_sel  = BIG_ENDIAN ? (WORD_BYTES - 1 - lane_k) : lane_k;

    unique case (state_q)
      S_REQ: begin
        if (bus.io_ready) begin
          read_req_d = 1'b1;
          state_d    = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.io_done) begin
          unique case (phase_q)
            PH_LEN: begin
              length_d = new_len;
              if (hdr_cnt_q == 3'(LEN_BYTES - 1)) begin
                hdr_cnt_d = 3'd0;
                if (new_len > 32'(MAX_BYTES)) begin
                  err_d   = 8'd1;
                  state_d = S_HALT;
                end else if (new_len == 32'd0) begin
                  if (CSUM_EN) begin
                    phase_d = PH_CSUM;
                    state_d = S_REQ;
                  end else begin
                    state_d = S_RUN;
                  end
                end else begin
                  phase_d = PH_DATA;
                  state_d = S_REQ;
                end
              end else begin
                hdr_cnt_d = hdr_cnt_q + 3'd1;
                state_d   = S_REQ;
              end
            end

            PH_DATA: begin
              for (int i = 0; i < WORD_BYTES; i++) begin
                if (i == lane_sel) begin
                  word_d[8*i +: 8] = bus.io_rdata;
                  lanes_d[i]       = 1'b1;
                end
              end
              sum_d   = sum_q + bus.io_rdata;
              bytes_d = bytes_q + 32'd1;
              // Flush on a completed word or on the final payload byte.
              if ((lane_k == WORD_BYTES - 1) || last_byte) begin
                state_d = S_WRITE;
              end else begin
                state_d = S_REQ;
              end
            end

            PH_CSUM: begin
              if (bus.io_rdata == sum_q) begin
                state_d = S_RUN;
              end else begin
                err_d   = 8'd2;
                state_d = S_HALT;
              end
            end

            default: state_d = S_HALT;
          endcase
        end
      end

      S_WRITE: begin
        word_d  = '0;
        lanes_d = '0;
        if (bytes_q == length_q) begin
          if (CSUM_EN) begin
            phase_d = PH_CSUM;
            state_d = S_REQ;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_REQ;
        end
      end

      S_RUN:   state_d = S_RUN;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_REQ;
      phase_q    <= PH_LEN;
      read_req_q <= 1'b0;
      hdr_cnt_q  <= 3'd0;
      length_q   <= 32'd0;
      bytes_q    <= 32'd0;
      sum_q      <= 8'd0;
      word_q     <= '0;
      lanes_q    <= '0;
      err_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      read_req_q <= read_req_d;
      hdr_cnt_q  <= hdr_cnt_d;
      length_q   <= length_d;
      bytes_q    <= bytes_d;
      sum_q      <= sum_d;
      word_q     <= word_d;
      lanes_q    <= lanes_d;
      err_q      <= err_d;
    end
  end

  // The write port is decoded from state, so a reset drops it on the same
  // edge. The address is that of the word holding the most recent byte.
  assign in_write        = (state_q == S_WRITE);
  assign word_off        = (bytes_q - 32'd1) & ~(32'(WORD_BYTES) - 32'd1);
  assign bus.mem_en      = in_write;
  assign bus.mem_we      = in_write ? lanes_q : '0;
  assign bus.mem_wdata   = in_write ? word_q : '0;
  assign bus.mem_addr    = in_write ? (BASE_ADDR + ADDR_W'(word_off)) : '0;
  assign bus.io_read_req = read_req_q;

  assign bytes_loaded = bytes_q;
  assign boot_ready   = (state_q == S_RUN);
  assign err          = err_q;
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_boot_stream_loader.sv
// tb_boot_stream_loader
//   Checks two loader instances.
//   dut_a: defaults (4-byte words, big-endian, checksum on).
//   dut_b: MAX_BYTES=16, little-endian, no checksum.
//   Each instance has a byte-source model that answers each strobe at the
//   following negedge, and a write monitor that pops expected BRAM writes
//   from a queue.
module tb_boot_stream_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  boot_stream_loader_if #(.WORD_BYTES(4), .ADDR_W(32)) ifa ();
  boot_stream_loader_if #(.WORD_BYTES(4), .ADDR_W(32)) ifb ();

  logic [31:0] bytes_loaded_a, bytes_loaded_b;
  logic        boot_ready_a, boot_ready_b;
  logic [7:0]  err_a, err_b;
  logic [2:0]  dbg_state_a, dbg_state_b;

  boot_stream_loader dut_a (
    .CLK(clk), .RST(rst), .bus(ifa),
    .bytes_loaded(bytes_loaded_a), .boot_ready(boot_ready_a),
    .err(err_a), .dbg_state(dbg_state_a)
  );

  boot_stream_loader #(.MAX_BYTES(16), .BIG_ENDIAN(1'b0), .CSUM_EN(1'b0)) dut_b (
    .CLK(clk), .RST(rst), .bus(ifb),
    .bytes_loaded(bytes_loaded_b), .boot_ready(boot_ready_b),
    .err(err_b), .dbg_state(dbg_state_b)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte sources and scoreboards
  logic [7:0]  src_q_a[$];
  logic [7:0]  src_q_b[$];
  logic [67:0] exp_q_a[$];  // {addr, data, we}
  logic [67:0] exp_q_b[$];
  logic        src_has_a = 1'b0, src_has_b = 1'b0;
  logic        hold_a = 1'b0, hold_b = 1'b0;
  int          strobes_a = 0, strobes_b = 0;
  int          last_done_a = 0, last_done_b = 0;

  assign ifa.io_ready = src_has_a && !hold_a;
  assign ifb.io_ready = src_has_b && !hold_b;

  always @(negedge clk) begin
    ifa.io_done = 1'b0;
    if (!rst && ifa.io_read_req) begin
      strobes_a++;
      check("a_strobe_with_data", 64'(src_q_a.size() != 0), 64'd1);
      if (src_q_a.size() != 0) begin
        ifa.io_rdata = src_q_a.pop_front();
        ifa.io_done  = 1'b1;
        last_done_a  = cyc;
      end
    end
    src_has_a = (src_q_a.size() != 0);
  end

  always @(negedge clk) begin
    ifb.io_done = 1'b0;
    if (!rst && ifb.io_read_req) begin
      strobes_b++;
      check("b_strobe_with_data", 64'(src_q_b.size() != 0), 64'd1);
      if (src_q_b.size() != 0) begin
        ifb.io_rdata = src_q_b.pop_front();
        ifb.io_done  = 1'b1;
        last_done_b  = cyc;
      end
    end
    src_has_b = (src_q_b.size() != 0);
  end

  always @(negedge clk) begin
    logic [67:0] e;
    if (ifa.mem_en === 1'b1) begin
      check("a_write_expected", 64'(exp_q_a.size() != 0), 64'd1);
      if (exp_q_a.size() != 0) begin
        e = exp_q_a.pop_front();
        check("a_wr_addr", 64'(ifa.mem_addr), 64'(e[67:36]));
        check("a_wr_data", 64'(ifa.mem_wdata), 64'(e[35:4]));
        check("a_wr_we", 64'(ifa.mem_we), 64'(e[3:0]));
      end
    end
  end

  always @(negedge clk) begin
    logic [67:0] e;
    if (ifb.mem_en === 1'b1) begin
      check("b_write_expected", 64'(exp_q_b.size() != 0), 64'd1);
      if (exp_q_b.size() != 0) begin
        e = exp_q_b.pop_front();
        check("b_wr_addr", 64'(ifb.mem_addr), 64'(e[67:36]));
        check("b_wr_data", 64'(ifb.mem_wdata), 64'(e[35:4]));
        check("b_wr_we", 64'(ifb.mem_we), 64'(e[3:0]));
      end
    end
  end

  task automatic push_a(input logic [7:0] b);
    src_q_a.push_back(b);
  endtask

  task automatic push_b(input logic [7:0] b);
    src_q_b.push_back(b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    src_q_a.delete();
    src_q_b.delete();
    exp_q_a.delete();
    exp_q_b.delete();
    hold_a = 1'b0;
    hold_b = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_frame1_a();
    logic [7:0] f1 [10];
    f1 = '{8'h00, 8'h08, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    foreach (f1[i]) push_a(f1[i]);
    push_a(8'h64);
    exp_q_a.push_back({32'h0, 32'h11223344, 4'hF});
    exp_q_a.push_back({32'h4, 32'h55667788, 4'hF});
  endtask

  task automatic wait_end_a(input int budget);
    for (int i = 0; i < budget && !boot_ready_a && err_a == 8'd0; i++) @(negedge clk);
  endtask

  task automatic wait_end_b(input int budget);
    for (int i = 0; i < budget && !boot_ready_b && err_b == 8'd0; i++) @(negedge clk);
  endtask

  initial begin
    int s0;
    int ready_cyc;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_boot_ready", 64'(boot_ready_a), 64'd0);
    check("rst_err", 64'(err_a), 64'd0);
    check("rst_bytes", 64'(bytes_loaded_a), 64'd0);
    check("rst_mem_en", 64'(ifa.mem_en), 64'd0);
    check("rst_read_req", 64'(ifa.io_read_req), 64'd0);
    check("rst_state", 64'(dbg_state_a), 64'd0);
    rst = 1'b0;

    // 1: two full big-endian words with checksum
    send_frame1_a();
    wait_end_a(300);
    ready_cyc = cyc;
    check("t1_boot_ready", 64'(boot_ready_a), 64'd1);
    check("t1_err", 64'(err_a), 64'd0);
    check("t1_bytes", 64'(bytes_loaded_a), 64'd8);
    check("t1_writes_seen", 64'(exp_q_a.size()), 64'd0);
    check("t1_ready_latency", 64'(ready_cyc - last_done_a), 64'd1);
    s0 = strobes_a;
    push_a(8'h99);
    repeat (6) @(negedge clk);
    check("t1_no_strobe_in_run", 64'(strobes_a - s0), 64'd0);

    // 2: partial final word
    do_reset();
    push_a(8'h00); push_a(8'h05);
    for (int i = 1; i <= 5; i++) push_a(8'(i));
    push_a(8'h0F);
    exp_q_a.push_back({32'h0, 32'h01020304, 4'hF});
    exp_q_a.push_back({32'h4, 32'h05000000, 4'h8});
    wait_end_a(300);
    check("t2_boot_ready", 64'(boot_ready_a), 64'd1);
    check("t2_err", 64'(err_a), 64'd0);
    check("t2_bytes", 64'(bytes_loaded_a), 64'd5);
    check("t2_writes_seen", 64'(exp_q_a.size()), 64'd0);

    // 3: checksum mismatch halts
    do_reset();
    push_a(8'h00); push_a(8'h03);
    push_a(8'hAA); push_a(8'hBB); push_a(8'hCC);
    push_a(8'h00);
    push_a(8'h55); push_a(8'h55);
    exp_q_a.push_back({32'h0, 32'hAABBCC00, 4'hE});
    wait_end_a(300);
    s0 = strobes_a;
    repeat (10) @(negedge clk);
    check("t3_err", 64'(err_a), 64'd2);
    check("t3_boot_ready", 64'(boot_ready_a), 64'd0);
    check("t3_no_strobe", 64'(strobes_a - s0), 64'd0);
    check("t3_src_left", 64'(src_q_a.size()), 64'd2);
    check("t3_writes_seen", 64'(exp_q_a.size()), 64'd0);

    // 4: oversized length on dut_b
    do_reset();
    s0 = strobes_b;
    push_b(8'h00); push_b(8'h20);
    push_b(8'h01); push_b(8'h02); push_b(8'h03);
    wait_end_b(200);
    repeat (10) @(negedge clk);
    check("t4_err", 64'(err_b), 64'd1);
    check("t4_boot_ready", 64'(boot_ready_b), 64'd0);
    check("t4_bytes", 64'(bytes_loaded_b), 64'd0);
    check("t4_strobes", 64'(strobes_b - s0), 64'd2);
    check("t4_src_left", 64'(src_q_b.size()), 64'd3);

    // 5: little-endian, no checksum, source stalls mid-payload
    do_reset();
    s0 = strobes_b;
    push_b(8'h00); push_b(8'h04);
    push_b(8'h11); push_b(8'h22); push_b(8'h33); push_b(8'h44);
    exp_q_b.push_back({32'h0, 32'h44332211, 4'hF});
    for (int i = 0; i < 200 && bytes_loaded_b != 32'd2; i++) @(negedge clk);
    check("t5_mid_bytes", 64'(bytes_loaded_b), 64'd2);
    hold_b = 1'b1;
    begin
      int s1;
      s1 = strobes_b;
      repeat (5) @(negedge clk);
      check("t5_no_strobe_stalled", 64'(strobes_b - s1), 64'd0);
      check("t5_stalled_state", 64'(dbg_state_b), 64'd0);
    end
    hold_b = 1'b0;
    wait_end_b(300);
    ready_cyc = cyc;
    check("t5_boot_ready", 64'(boot_ready_b), 64'd1);
    check("t5_err", 64'(err_b), 64'd0);
    check("t5_strobes", 64'(strobes_b - s0), 64'd6);
    check("t5_writes_seen", 64'(exp_q_b.size()), 64'd0);
    check("t5_ready_latency", 64'(ready_cyc - last_done_b), 64'd2);

    // 6: reset during a BRAM write, then a clean reload
    do_reset();
    send_frame1_a();
    for (int i = 0; i < 300 && ifa.mem_en !== 1'b1; i++) @(negedge clk);
    check("t6_in_write", 64'(ifa.mem_en), 64'd1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_mem_en_dropped", 64'(ifa.mem_en), 64'd0);
    check("t6_mem_we_dropped", 64'(ifa.mem_we), 64'd0);
    check("t6_bytes_cleared", 64'(bytes_loaded_a), 64'd0);
    do_reset();
    send_frame1_a();
    wait_end_a(300);
    check("t6_boot_ready", 64'(boot_ready_a), 64'd1);
    check("t6_err", 64'(err_a), 64'd0);
    check("t6_bytes", 64'(bytes_loaded_a), 64'd8);
    check("t6_writes_seen", 64'(exp_q_a.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
